// File: rtl/wide_add_sequencer_pkg.sv
// Shared ALU-level definitions: sequencer state encoding, slice width,
// default operand size and the signed-overflow flag helper.
package wide_add_sequencer_pkg;

    localparam int DEFAULT_BYTES = 4;
    localparam int SLICE_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_cla_adder.sv
// Small carry-lookahead adder. Every carry is formed directly from the
// generate/propagate terms and c_in rather than rippling.
module cla_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         prop;
    logic         gen;

    assign g = a & b;
    assign p = a ^ b;

    // Expand each carry as g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
    always_comb begin
        c    = '0;
        prop = 1'b0;
        gen  = 1'b0;
        c[0] = c_in;
        for (int i = 0; i < W; i++) begin
            prop = p[i];
            gen  = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen  = gen | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = gen | (prop & c_in);
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign c_out = c[W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder/subtractor. One 8-bit adder is reused each RUN
// cycle, least-significant byte first, with the carry held in a register.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int BYTES = DEFAULT_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [8*BYTES-1:0]   a,
    input  logic [8*BYTES-1:0]   b,
    output logic [8*BYTES-1:0]   result,
    output logic                 c_out,
    output logic                 overflow,
    output logic                 zero,
    output logic                 busy,
    output logic                 done
);

    localparam int W     = SLICE_W * BYTES;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;      // already inverted when subtracting
    logic             sub_reg;

    logic             accept;
    logic             running;
    logic             last_byte;

    logic [SLICE_W-1:0] a_slice [BYTES];
    logic [SLICE_W-1:0] b_slice [BYTES];
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cin;
    logic               slice_cout;
    logic [W-1:0]       merged;   // result with the current byte written in

    assign accept    = (state_reg == ST_IDLE) && start;
    assign running   = (state_reg == ST_RUN);
    assign last_byte = running && (idx_reg == LAST_IDX);

    // Byte views of the latched operands, and the merge of the new sum byte.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
            assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign merged[gi*SLICE_W +: SLICE_W] =
                (idx_reg == IDX_W'(gi)) ? slice_sum : result[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_a   = a_slice[idx_reg];
    assign slice_b   = b_slice[idx_reg];
    assign slice_cin = (idx_reg == '0) ? sub_reg : carry_reg;

    cla_adder #(
        .W     (SLICE_W)
    ) u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (slice_cin),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: IDLE -> RUN on start, RUN -> DONE after the top byte,
    // DONE always returns to IDLE so held start leaves one IDLE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_byte) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-byte accumulation and final flag registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            result    <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            sub_reg <= sub;
            idx_reg <= '0;
            result  <= '0;
        end else if (running) begin
            result    <= merged;
            carry_reg <= slice_cout;
            idx_reg   <= last_byte ? '0 : idx_reg + 1'b1;
            if (last_byte) begin
                c_out    <= slice_cout;
                overflow <= signed_overflow(a_reg[W-1], b_reg[W-1], slice_sum[SLICE_W-1]);
                zero     <= (merged == '0);
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed vector table,
// randomized operations against an arithmetic reference, and hand-written
// sequences for busy rejection, back-to-back start and reset mid-operation.
module tb_wide_add_sequencer;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;
    logic         zero;
    logic         busy;
    logic         done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wide_add_sequencer #(
        .BYTES    (BYTES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain unsigned/signed arithmetic on whole 32-bit values.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] r, output logic co, output logic ov,
                         output logic z);
        longint sx, sy, sres;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r    = x - y;
            co   = (x >= y);
            sres = sx - sy;
        end else begin
            {co, r} = {1'b0, x} + {1'b0, y};
            sres    = sx + sy;
        end
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        z  = (r == 32'd0);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns likewise.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] er, input logic ec, input logic eo,
                          input logic ez, input string tag);
        int k;
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom_range(0, 1));
        check({tag, "_cleared"}, result, 32'd0);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'd4);
        check({tag, "_result"}, result, er);
        check({tag, "_c_out"}, 32'(c_out), 32'(ec));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        $display("op %s a=%h b=%h sub=%0d -> result=%h c_out=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, x, y, s, result, c_out, overflow, zero, k);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] x, y, er;
        logic        s, ec, eo, ez;
        int          dcount;
        int          first_pos, second_pos;
        logic [31:0] cap;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        // Reset takes effect before any clock edge.
        #2;
        check("reset_result", result, 32'd0);
        check("reset_flags", {27'd0, c_out, overflow, zero, busy, done}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].cout,
                   vecs[i].ovf, vecs[i].zero, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) y = ~x;
            if (i % 7 == 0) y = x;
            model(x, y, s, er, ec, eo, ez);
            run_op(x, y, s, er, ec, eo, ez, $sformatf("rnd%0d", i));
        end

        // Busy rejection: second start one cycle later must be ignored.
        start = 1'b1; a = 32'h10; b = 32'h20; sub = 1'b0;
        @(posedge clk); #1;
        a = 32'h1; b = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        cap    = '0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                dcount++;
                cap = result;
            end
            @(posedge clk); #1;
        end
        check("busy_rej_dones", 32'(dcount), 32'd1);
        check("busy_rej_result", cap, 32'h30);
        $display("op busy_rej dones=%0d result=%h", dcount, cap);

        // Start held high: completions six cycles apart.
        start = 1'b1; a = 32'd3; b = 32'd4; sub = 1'b0;
        dcount = 0; first_pos = -1; second_pos = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dcount++;
                if (first_pos < 0) first_pos = k;
                else if (second_pos < 0) second_pos = k;
                cap = result;
            end
        end
        start = 1'b0;
        check("b2b_dones", 32'(dcount), 32'd3);
        check("b2b_gap", 32'(second_pos - first_pos), 32'd6);
        check("b2b_result", cap, 32'd7);
        $display("op b2b dones=%0d gap=%0d result=%h", dcount, second_pos - first_pos, cap);
        for (int k = 0; k < 10 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("b2b_drain", 32'(busy), 32'd0);

        // Idle with start low: outputs hold while inputs wiggle.
        for (int k = 0; k < 3; k++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("idle_hold_result", result, 32'd7);
        check("idle_hold_ctl", {30'd0, busy, done}, 32'd0);

        // Reset after two RUN cycles aborts with no done pulse.
        start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_flags", {27'd0, c_out, overflow, zero, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        $display("op midrst dones_after=%0d", dcount);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL expose one clock and an asynchronous, active-high reset.
REQ-002 Port list (name, direction, width, meaning), one per line:
  clk  input  1  rising-edge clock
  rst  input  1  async active-high reset
  start  input  1  request; sampled only in IDLE
  sub  input  1  0 = a+b, 1 = a-b; latched with operands
  a  input  32  operand A
  b  input  32  operand B
  result  output  32  sum/difference; holds until next accepted start
  c_out  output  1  carry out of bit 31 (sub: 1 = no borrow)
  overflow  output  1  signed two's-complement overflow
  zero  output  1  result == 0
  busy  output  1  high in RUN and DONE
  done  output  1  one-cycle completion pulse
REQ-003 Parameter: BYTES, default 4, number of 8-bit slices (operand width = 8*BYTES).

Function
REQ-004 States SHALL be IDLE, RUN and DONE.
REQ-005 IDLE with start=1 at edge N SHALL latch a, b and sub, set byte index to 0, clear result, and enter RUN.
REQ-006 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-007 Each RUN edge SHALL add one byte through a single 8-bit adder, least-significant byte first.
  - Operand slices: a[8i+7:8i] and b'[8i+7:8i], where b' = sub ? ~b : b.
  - Carry-in: byte 0 uses sub; later bytes use the registered carry from the previous byte.
REQ-008 Each RUN edge SHALL write the 8-bit sum into result[8i+7:8i] and register the adder carry out.
REQ-009 The byte index SHALL increment each RUN edge; on the edge processing index BYTES-1 (edge N+BYTES), the state SHALL become DONE.
REQ-010 c_out SHALL be the registered carry from the top byte.
REQ-011 overflow SHALL equal (a[31] == b'[31]) && (result[31] != a[31]).
REQ-012 zero SHALL equal (result == 0).
REQ-013 c_out, overflow and zero SHALL update at edge N+BYTES, together with the final result byte.
REQ-014 done SHALL be high for exactly the one cycle spent in DONE (after edge N+BYTES); the next edge SHALL return to IDLE.
REQ-015 Latency: start accepted at edge N gives done high during cycle N+BYTES to N+BYTES+1 (4 clocks for BYTES=4).
REQ-016 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-017 start held high continuously SHALL produce back-to-back operations, each separated by one IDLE cycle.
REQ-018 Changes on a, b or sub after acceptance SHALL NOT affect the operation in progress.
REQ-019 Partial result bytes MAY be visible during RUN; result is valid only from done onward.
REQ-020 Arithmetic SHALL be modulo 2^(8*BYTES); no saturation.

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force the following values:
  - state = IDLE, byte index = 0, carry register = 0;
  - result = 0, c_out = 0, overflow = 0, zero = 0, busy = 0, done = 0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-023 After reset deasserts, the first start seen in IDLE SHALL be accepted normally.

Structure
REQ-024 The state encoding (IDLE/RUN/DONE) and the BYTES default SHALL live in a shared ALU package/header reused by ALU-level blocks.
REQ-025 Exactly one sub-module SHALL be instantiated: cla_adder (8-bit a, b, c_in, sum, c_out), reused each RUN cycle.
REQ-026 No other arithmetic SHALL exist in the block beyond index increment, the b inversion and flag logic.

Verification
REQ-027 Carry chain: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, c_out=1, zero=1, overflow=0; done pulses exactly 4 clocks after the start edge.
REQ-028 Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, overflow=1, c_out=0, zero=0.
REQ-029 Subtract with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFE, c_out=0, overflow=0. Then a=7, b=5, sub=1 -> result=2, c_out=1.
REQ-030 Busy rejection: start pulsed at cycles 1 and 2 with different operands (0x10+0x20, then 0x1+0x1) -> exactly one done pulse; result=0x00000030.
REQ-031 Reset mid-op: start 0x12345678+0x11111111, assert rst after 2 RUN cycles -> all outputs 0 and no done pulse. A new start of 0x12345678+0x11111111 -> result=0x23456789.
